// File: rtl/vlane_shifter_pipe_pkg.sv
// vlane_shifter_pipe_pkg: op encodings, op field indices and per-stage shift-amount slicing helpers
package vlane_shifter_pipe_pkg;
  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b011,
    OP_ROL = 3'b100,
    OP_ROR = 3'b101
  } op_e;
  localparam int OP_DIR = 0;
  localparam int OP_SEXT = 1;
  localparam int OP_ROT = 2;
  function automatic int slice_top(int l, int n, int i);
    return l - i * ((l + n - 1) / n);
  endfunction
  function automatic int slice_lo(int l, int n, int i);
    int t;
    t = slice_top(l, n, i) - (l + n - 1) / n;
    return t < 0 ? 0 : t;
  endfunction
  function automatic int slice_w(int l, int n, int i);
    int t;
    t = slice_top(l, n, i);
    return t <= 0 ? 0 : t - slice_lo(l, n, i);
  endfunction
endpackage

// File: rtl/vlane_shifter_pipe_if.sv
// vlane_shifter_pipe_if: issue/result bundle of the lane shifter
interface vlane_shifter_pipe_if #(
  parameter int WIDTH = 32,
  parameter int LOG2WIDTH = 5,
  parameter int TAGWIDTH = 8
);
  logic in_valid;
  logic [WIDTH-1:0] opB;
  logic [LOG2WIDTH-1:0] sa;
  logic [2:0] op;
  logic [TAGWIDTH-1:0] in_tag;
  logic stall;
  logic squash;
  logic out_valid;
  logic [WIDTH-1:0] result;
  logic [TAGWIDTH-1:0] out_tag;
  modport master (
    output in_valid, opB, sa, op, in_tag, stall, squash,
    input out_valid, result, out_tag
  );
  modport slave (
    input in_valid, opB, sa, op, in_tag, stall, squash,
    output out_valid, result, out_tag
  );
endinterface

// File: rtl/vlane_shifter_pipe_stage.sv
// vlane_shifter_pipe_stage: log-shifter over one shift-amount slice followed by a controlled register
module vlane_shifter_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int LOG2WIDTH = 5,
  parameter int TAGWIDTH = 8,
  parameter int SLICEW = 1,
  parameter int SLICELO = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 stall,
  input  logic                 squash,
  input  logic                 in_valid,
  input  logic                 in_fill,
  input  logic                 in_dir,
  input  logic                 in_rot,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [LOG2WIDTH-1:0] in_sa,
  input  logic [TAGWIDTH-1:0]  in_tag,
  output logic                 out_valid,
  output logic                 out_fill,
  output logic                 out_dir,
  output logic                 out_rot,
  output logic [WIDTH-1:0]     out_data,
  output logic [LOG2WIDTH-1:0] out_sa,
  output logic [TAGWIDTH-1:0]  out_tag
);
  logic [WIDTH-1:0] v;
  always_comb begin
    v = in_data;
    for (int j = 0; j < LOG2WIDTH; j++)
      if (j >= SLICELO && j < SLICELO + SLICEW && in_sa[j])
        v = in_rot ? (in_dir ? (v >> (1 << j)) | (v << (WIDTH - (1 << j)))
                             : (v << (1 << j)) | (v >> (WIDTH - (1 << j))))
                   : (in_dir ? (v >> (1 << j)) | (in_fill ? ~({WIDTH{1'b1}} >> (1 << j)) : '0)
                             : v << (1 << j));
  end
  always_ff @(posedge clk)
    if (resetn)
      {out_valid, out_fill, out_dir, out_rot, out_data, out_sa, out_tag} <= '0;
    else if (squash)
      out_valid <= 1'b0;
    else if (!stall) begin
      out_valid <= in_valid;
      out_fill <= in_fill;
      out_dir <= in_dir;
      out_rot <= in_rot;
      out_data <= v;
      out_sa <= in_sa;
      out_tag <= in_tag;
    end
endmodule

// File: rtl/vlane_shifter_pipe.sv
// vlane_shifter_pipe: pipelined barrel shifter/rotator with valid, stall, squash and tag pass-through
module vlane_shifter_pipe
  import vlane_shifter_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LOG2WIDTH = 5,
  parameter int NUMSTAGES = 2,
  parameter int TAGWIDTH = 8
) (
  input logic clk,
  input logic resetn,
  vlane_shifter_pipe_if.slave bus
);
  logic vld [NUMSTAGES+1];
  logic fill [NUMSTAGES+1];
  logic dir [NUMSTAGES+1];
  logic rot [NUMSTAGES+1];
  logic [WIDTH-1:0] dat [NUMSTAGES+1];
  logic [LOG2WIDTH-1:0] sa [NUMSTAGES+1];
  logic [TAGWIDTH-1:0] tag [NUMSTAGES+1];
  assign vld[0] = bus.in_valid;
  assign fill[0] = bus.opB[WIDTH-1] & bus.op[OP_SEXT] & ~bus.op[OP_ROT];
  assign dir[0] = bus.op[OP_DIR];
  assign rot[0] = bus.op[OP_ROT];
  assign dat[0] = bus.opB;
  assign sa[0] = bus.sa;
  assign tag[0] = bus.in_tag;
  for (genvar i = 0; i < NUMSTAGES; i++) begin : g_stage
    vlane_shifter_pipe_stage #(
      .WIDTH(WIDTH),
      .LOG2WIDTH(LOG2WIDTH),
      .TAGWIDTH(TAGWIDTH),
      .SLICEW(slice_w(LOG2WIDTH, NUMSTAGES, i)),
      .SLICELO(slice_lo(LOG2WIDTH, NUMSTAGES, i))
    ) u_stage (
      .clk(clk),
      .resetn(resetn),
      .stall(bus.stall),
      .squash(bus.squash),
      .in_valid(vld[i]),
      .in_fill(fill[i]),
      .in_dir(dir[i]),
      .in_rot(rot[i]),
      .in_data(dat[i]),
      .in_sa(sa[i]),
      .in_tag(tag[i]),
      .out_valid(vld[i+1]),
      .out_fill(fill[i+1]),
      .out_dir(dir[i+1]),
      .out_rot(rot[i+1]),
      .out_data(dat[i+1]),
      .out_sa(sa[i+1]),
      .out_tag(tag[i+1])
    );
  end
  assign bus.out_valid = vld[NUMSTAGES];
  assign bus.result = dat[NUMSTAGES];
  assign bus.out_tag = tag[NUMSTAGES];
endmodule

// File: tb/tb_vlane_shifter_pipe.sv
// tb_vlane_shifter_pipe: directed checks on the 32-bit/2-stage shifter plus a depth and width sweep
module tb_vlane_shifter_pipe;
  import vlane_shifter_pipe_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  vlane_shifter_pipe_if #(.WIDTH(32), .LOG2WIDTH(5), .TAGWIDTH(8)) m();
  vlane_shifter_pipe_if #(.WIDTH(32), .LOG2WIDTH(5), .TAGWIDTH(8)) s1();
  vlane_shifter_pipe_if #(.WIDTH(32), .LOG2WIDTH(5), .TAGWIDTH(8)) s3();
  vlane_shifter_pipe_if #(.WIDTH(32), .LOG2WIDTH(5), .TAGWIDTH(8)) s5();
  vlane_shifter_pipe_if #(.WIDTH(64), .LOG2WIDTH(6), .TAGWIDTH(8)) s64();
  vlane_shifter_pipe #(.WIDTH(32), .LOG2WIDTH(5), .NUMSTAGES(2), .TAGWIDTH(8)) dut (.clk(clk), .resetn(resetn), .bus(m));
  vlane_shifter_pipe #(.WIDTH(32), .LOG2WIDTH(5), .NUMSTAGES(1), .TAGWIDTH(8)) dut1 (.clk(clk), .resetn(resetn), .bus(s1));
  vlane_shifter_pipe #(.WIDTH(32), .LOG2WIDTH(5), .NUMSTAGES(3), .TAGWIDTH(8)) dut3 (.clk(clk), .resetn(resetn), .bus(s3));
  vlane_shifter_pipe #(.WIDTH(32), .LOG2WIDTH(5), .NUMSTAGES(5), .TAGWIDTH(8)) dut5 (.clk(clk), .resetn(resetn), .bus(s5));
  vlane_shifter_pipe #(.WIDTH(64), .LOG2WIDTH(6), .NUMSTAGES(4), .TAGWIDTH(8)) dut64 (.clk(clk), .resetn(resetn), .bus(s64));
  logic sw_valid = 1'b0;
  logic [63:0] sw_b = '0;
  logic [5:0] sw_sa = '0;
  logic [2:0] sw_op = '0;
  logic [7:0] sw_tag = '0;
  assign {s1.in_valid, s1.opB, s1.sa, s1.op, s1.in_tag, s1.stall, s1.squash} = {sw_valid, sw_b[31:0], sw_sa[4:0], sw_op, sw_tag, 2'b00};
  assign {s3.in_valid, s3.opB, s3.sa, s3.op, s3.in_tag, s3.stall, s3.squash} = {sw_valid, sw_b[31:0], sw_sa[4:0], sw_op, sw_tag, 2'b00};
  assign {s5.in_valid, s5.opB, s5.sa, s5.op, s5.in_tag, s5.stall, s5.squash} = {sw_valid, sw_b[31:0], sw_sa[4:0], sw_op, sw_tag, 2'b00};
  assign {s64.in_valid, s64.opB, s64.sa, s64.op, s64.in_tag, s64.stall, s64.squash} = {sw_valid, sw_b, sw_sa, sw_op, sw_tag, 2'b00};
  localparam int NV = 9;
  logic [63:0] sv_b [NV] = '{64'hF0E1D2C3_B4A59687, 64'h80000000_00000001, 64'h81234567_89ABCDEF,
                             64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567, 64'h00000001_80000000,
                             64'hFFFFFFFF_FFFFFFFF, 64'h12345678_9ABCDEF0, 64'hCAFEF00D_8BADF00D};
  logic [5:0] sv_sa [NV] = '{6'd13, 6'd37, 6'd63, 6'd20, 6'd45, 6'd31, 6'd17, 6'd0, 6'd33};
  logic [2:0] sv_op [NV] = '{3'b000, 3'b011, 3'b011, 3'b100, 3'b101, 3'b001, 3'b010, 3'b111, 3'b110};
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(logic v, logic [2:0] op, logic [31:0] b, logic [4:0] sa, logic [7:0] tag);
    m.in_valid = v;
    m.op = op;
    m.opB = b;
    m.sa = sa;
    m.in_tag = tag;
  endtask
  task automatic run_op(string n, logic [2:0] op, logic [31:0] b, logic [4:0] sa, logic [31:0] exp);
    put(1'b1, op, b, sa, {op, sa});
    tick();
    put(1'b0, 3'b000, 32'h0, 5'd0, 8'h00);
    chk({n, "_lat1"}, {63'b0, m.out_valid}, 64'd0);
    tick();
    chk({n, "_valid"}, {63'b0, m.out_valid}, 64'd1);
    chk({n, "_res"}, {32'b0, m.result}, {32'b0, exp});
    chk({n, "_tag"}, {56'b0, m.out_tag}, {56'b0, op, sa});
    tick();
    chk({n, "_drain"}, {63'b0, m.out_valid}, 64'd0);
  endtask
  function automatic logic [63:0] model(logic [63:0] b, int sa, logic [2:0] op, int w);
    logic [63:0] mask, x, r;
    mask = (w == 64) ? '1 : (64'h1 << w) - 64'h1;
    x = b & mask;
    if (op[2])
      r = op[0] ? (x >> sa) | (x << (w - sa)) : (x << sa) | (x >> (w - sa));
    else if (op[0]) begin
      r = x >> sa;
      if (op[1] && x[w-1]) r = r | (mask & ~(mask >> sa));
    end else
      r = x << sa;
    return r & mask;
  endfunction
  task automatic sweep_chk(string n, int lat, int w, int c, logic v, logic [63:0] r, logic [7:0] t);
    int idx;
    logic ok;
    idx = c + 1 - lat;
    ok = idx >= 0 && idx < NV;
    chk($sformatf("%s_c%0d_valid", n, c), {63'b0, v}, {63'b0, ok});
    if (ok) begin
      chk($sformatf("%s_v%0d_res", n, idx), r,
          model(sv_b[idx], (w == 32) ? int'(sv_sa[idx][4:0]) : int'(sv_sa[idx]), sv_op[idx], w));
      chk($sformatf("%s_v%0d_tag", n, idx), {56'b0, t}, 64'hA0 + 64'(idx));
    end
  endtask
  initial begin
    put(1'b0, 3'b000, 32'h0, 5'd0, 8'h00);
    m.stall = 1'b0;
    m.squash = 1'b0;
    tick();
    tick();
    chk("rst_valid", {63'b0, m.out_valid}, 64'd0);
    chk("rst_res", {32'b0, m.result}, 64'd0);
    chk("rst_tag", {56'b0, m.out_tag}, 64'd0);
    resetn = 1'b0;
    run_op("sll31", OP_SLL, 32'h00000001, 5'd31, 32'h80000000);
    run_op("sra4", OP_SRA, 32'h80000000, 5'd4, 32'hF8000000);
    run_op("srl4", OP_SRL, 32'h80000000, 5'd4, 32'h08000000);
    run_op("ror4", OP_ROR, 32'h000000F1, 5'd4, 32'h1000000F);
    run_op("rol1", OP_ROL, 32'h80000001, 5'd1, 32'h00000003);
    run_op("sll0", OP_SLL, 32'hA5C30F81, 5'd0, 32'hA5C30F81);
    run_op("srl0", OP_SRL, 32'hA5C30F81, 5'd0, 32'hA5C30F81);
    run_op("sra0", OP_SRA, 32'hA5C30F81, 5'd0, 32'hA5C30F81);
    run_op("rol0", OP_ROL, 32'hA5C30F81, 5'd0, 32'hA5C30F81);
    run_op("ror0", OP_ROR, 32'hA5C30F81, 5'd0, 32'hA5C30F81);
    run_op("op010", 3'b010, 32'h8000000F, 5'd4, 32'h000000F0);
    run_op("op110", 3'b110, 32'h80000001, 5'd1, 32'h00000003);
    run_op("op111", 3'b111, 32'h000000F1, 5'd4, 32'h1000000F);
    run_op("sra31neg", OP_SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF);
    run_op("sra31pos", OP_SRA, 32'h70000000, 5'd31, 32'h00000000);
    run_op("ror31", OP_ROR, 32'h00000001, 5'd31, 32'h00000002);
    put(1'b1, OP_SLL, 32'h1, 5'd3, 8'd1);
    tick();
    put(1'b1, OP_SRL, 32'h100, 5'd4, 8'd2);
    tick();
    chk("b2b_t1_valid", {63'b0, m.out_valid}, 64'd1);
    chk("b2b_t1_tag", {56'b0, m.out_tag}, 64'd1);
    put(1'b1, OP_ROL, 32'hF0000000, 5'd4, 8'd3);
    m.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_valid", k), {63'b0, m.out_valid}, 64'd1);
      chk($sformatf("stall%0d_tag", k), {56'b0, m.out_tag}, 64'd1);
      chk($sformatf("stall%0d_res", k), {32'b0, m.result}, 64'h8);
    end
    m.stall = 1'b0;
    tick();
    put(1'b0, 3'b000, 32'h0, 5'd0, 8'h00);
    chk("b2b_t2_valid", {63'b0, m.out_valid}, 64'd1);
    chk("b2b_t2_tag", {56'b0, m.out_tag}, 64'd2);
    chk("b2b_t2_res", {32'b0, m.result}, 64'h10);
    tick();
    chk("b2b_t3_valid", {63'b0, m.out_valid}, 64'd1);
    chk("b2b_t3_tag", {56'b0, m.out_tag}, 64'd3);
    chk("b2b_t3_res", {32'b0, m.result}, 64'hF);
    tick();
    chk("b2b_end_valid", {63'b0, m.out_valid}, 64'd0);
    put(1'b1, OP_SLL, 32'h1, 5'd1, 8'h21);
    tick();
    put(1'b1, OP_SLL, 32'h1, 5'd2, 8'h22);
    tick();
    chk("sq_pre_valid", {63'b0, m.out_valid}, 64'd1);
    put(1'b1, OP_SLL, 32'h1, 5'd3, 8'h23);
    m.squash = 1'b1;
    tick();
    m.squash = 1'b0;
    put(1'b0, 3'b000, 32'h0, 5'd0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sq%0d_valid", k), {63'b0, m.out_valid}, 64'd0);
      tick();
    end
    put(1'b1, OP_SLL, 32'h1, 5'd3, 8'h77);
    tick();
    put(1'b1, OP_ROR, 32'hF1, 5'd4, 8'h78);
    tick();
    chk("rstmid_pre_tag", {56'b0, m.out_tag}, 64'h77);
    resetn = 1'b1;
    tick();
    chk("rstmid_valid", {63'b0, m.out_valid}, 64'd0);
    chk("rstmid_res", {32'b0, m.result}, 64'd0);
    chk("rstmid_tag", {56'b0, m.out_tag}, 64'd0);
    resetn = 1'b0;
    put(1'b0, 3'b000, 32'h0, 5'd0, 8'h00);
    tick();
    chk("rstmid_lost_valid", {63'b0, m.out_valid}, 64'd0);
    tick();
    for (int c = 0; c < NV + 6; c++) begin
      sw_valid = c < NV;
      sw_b = (c < NV) ? sv_b[c] : '0;
      sw_sa = (c < NV) ? sv_sa[c] : '0;
      sw_op = (c < NV) ? sv_op[c] : '0;
      sw_tag = 8'hA0 + 8'(c);
      tick();
      sweep_chk("n1", 1, 32, c, s1.out_valid, {32'b0, s1.result}, s1.out_tag);
      sweep_chk("n3", 3, 32, c, s3.out_valid, {32'b0, s3.result}, s3.out_tag);
      sweep_chk("n5", 5, 32, c, s5.out_valid, {32'b0, s5.result}, s5.out_tag);
      sweep_chk("w64", 4, 64, c, s64.out_valid, s64.result, s64.out_tag);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
